// File: rtl/game_pkg.sv
// game_pkg: shared key count, capture FSM encoding and debounce constants
package game_pkg;
    localparam int NUM_KEYS = 4;
    localparam int DEBOUNCE_CYCLES_DEFAULT = 500000;
    localparam int DEBOUNCE_CYCLES_SIM = 4;
    typedef enum logic {ARMED = 1'b0, HOLD = 1'b1} cap_state_t;
endpackage

// File: rtl/key_debouncer.sv
// key_debouncer: synchronises one active-low raw key and debounces it into an active-high level
module key_debouncer #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic reset,
    input  logic key_n,
    output logic level
);
    localparam int CW = DEBOUNCE_CYCLES > 1 ? $clog2(DEBOUNCE_CYCLES) : 1;
    logic [1:0] sync;
    logic deb_n;
    logic [CW-1:0] cnt;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync  <= 2'b11;
            deb_n <= 1'b1;
            cnt   <= '0;
        end else begin
            sync <= {sync[0], key_n};
            if (sync[1] == deb_n)
                cnt <= '0;
            else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                deb_n <= sync[1];
                cnt   <= '0;
            end else
                cnt <= cnt + 1'b1;
        end
    end
    assign level = ~deb_n;
endmodule

// File: rtl/note_input_capture.sv
// note_input_capture: debounced keys to one-shot captured notes under a valid/ack handshake
module note_input_capture
    import game_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_KEYS-1:0] key_n,
    input  logic                enable,
    input  logic                note_ack,
    output logic [NUM_KEYS-1:0] note_out,
    output logic                note_valid,
    output logic [NUM_KEYS-1:0] keys_level,
    output logic                overrun
);
    cap_state_t state;
    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
        key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
            .clk  (clk),
            .reset(reset),
            .key_n(key_n[k]),
            .level(keys_level[k])
        );
    end
    // A capture in the same edge as an ack overrides the clear, so no note is lost.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ARMED;
            note_out   <= '0;
            note_valid <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            if (note_ack)
                note_valid <= 1'b0;
            if (state == ARMED) begin
                if (|keys_level) begin
                    state <= HOLD;
                    if (enable && (!note_valid || note_ack)) begin
                        note_out   <= keys_level;
                        note_valid <= 1'b1;
                    end else if (enable)
                        overrun <= 1'b1;
                end
            end else if (keys_level == '0)
                state <= ARMED;
        end
    end
endmodule

// File: tb/tb_note_input_capture.sv
// tb_note_input_capture: directed checks of debounce latency, capture, handshake and overrun
module tb_note_input_capture;
    import game_pkg::*;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] key_n = 4'hF;
    logic       enable = 1'b1;
    logic       note_ack = 1'b0;
    logic [3:0] note_out;
    logic       note_valid;
    logic [3:0] keys_level;
    logic       overrun;
    int checks = 0;
    int fails = 0;

    note_input_capture #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES_SIM)) dut (
        .clk       (clk),
        .reset     (reset),
        .key_n     (key_n),
        .enable    (enable),
        .note_ack  (note_ack),
        .note_out  (note_out),
        .note_valid(note_valid),
        .keys_level(keys_level),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
        checks++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    task automatic ack_pulse;
        note_ack = 1'b1;
        tick(1);
        note_ack = 1'b0;
    endtask

    initial begin
        tick(3);
        chk("rst_note_out", note_out, 4'b0000);
        chk("rst_valid", {3'b0, note_valid}, 4'b0000);
        chk("rst_level", keys_level, 4'b0000);
        chk("rst_overrun", {3'b0, overrun}, 4'b0000);
        reset = 1'b0;
        tick(2);

        // 1: basic press, latency and ack
        key_n = 4'b1011;
        tick(5);
        chk("t1_level_e5", keys_level, 4'b0000);
        tick(1);
        chk("t1_level_e6", keys_level, 4'b0100);
        chk("t1_valid_e6", {3'b0, note_valid}, 4'b0000);
        tick(1);
        chk("t1_valid_e7", {3'b0, note_valid}, 4'b0001);
        chk("t1_note_e7", note_out, 4'b0100);
        ack_pulse();
        chk("t1_acked", {3'b0, note_valid}, 4'b0000);
        key_n = 4'hF;
        tick(5);
        chk("t1_rel_e5", keys_level, 4'b0100);
        tick(1);
        chk("t1_rel_e6", keys_level, 4'b0000);
        tick(2);

        // 2: bounce shorter than the debounce window
        key_n = 4'b1110;
        tick(3);
        key_n = 4'b1111;
        tick(1);
        key_n = 4'b1110;
        tick(3);
        chk("t2_level_mid", keys_level, 4'b0000);
        key_n = 4'hF;
        tick(8);
        chk("t2_level_end", keys_level, 4'b0000);
        chk("t2_valid", {3'b0, note_valid}, 4'b0000);

        // 3: second key during hold is ignored
        key_n = 4'b1101;
        tick(7);
        chk("t3_note", note_out, 4'b0010);
        chk("t3_valid", {3'b0, note_valid}, 4'b0001);
        key_n = 4'b0101;
        ack_pulse();
        chk("t3_acked", {3'b0, note_valid}, 4'b0000);
        tick(8);
        chk("t3_level_both", keys_level, 4'b1010);
        chk("t3_no_recap", {3'b0, note_valid}, 4'b0000);
        key_n = 4'hF;
        tick(8);
        chk("t3_level_rel", keys_level, 4'b0000);
        chk("t3_no_cap_rel", {3'b0, note_valid}, 4'b0000);

        // 4: press while a note is pending sets overrun
        key_n = 4'b1110;
        tick(7);
        chk("t4_note0", note_out, 4'b0001);
        key_n = 4'hF;
        tick(8);
        key_n = 4'b1011;
        tick(6);
        chk("t4_ovr_before", {3'b0, overrun}, 4'b0000);
        tick(1);
        chk("t4_ovr_after", {3'b0, overrun}, 4'b0001);
        chk("t4_note_kept", note_out, 4'b0001);
        chk("t4_valid", {3'b0, note_valid}, 4'b0001);
        key_n = 4'hF;
        tick(8);

        // 5: ack coincident with a new capture
        key_n = 4'b0111;
        tick(6);
        note_ack = 1'b1;
        tick(1);
        note_ack = 1'b0;
        chk("t5_valid", {3'b0, note_valid}, 4'b0001);
        chk("t5_note", note_out, 4'b1000);
        chk("t5_ovr_sticky", {3'b0, overrun}, 4'b0001);
        ack_pulse();
        chk("t5_acked", {3'b0, note_valid}, 4'b0000);
        key_n = 4'hF;
        tick(8);

        // 6: reset during hold, then recapture of the still-held key
        key_n = 4'b1101;
        tick(7);
        chk("t6_pre_note", note_out, 4'b0010);
        reset = 1'b1;
        #2;
        chk("t6_rst_note", note_out, 4'b0000);
        chk("t6_rst_valid", {3'b0, note_valid}, 4'b0000);
        chk("t6_rst_level", keys_level, 4'b0000);
        chk("t6_rst_ovr", {3'b0, overrun}, 4'b0000);
        tick(2);
        reset = 1'b0;
        tick(6);
        chk("t6_level_e6", keys_level, 4'b0010);
        chk("t6_valid_e6", {3'b0, note_valid}, 4'b0000);
        tick(1);
        chk("t6_valid_e7", {3'b0, note_valid}, 4'b0001);
        chk("t6_note_e7", note_out, 4'b0010);
        ack_pulse();
        key_n = 4'hF;
        tick(8);

        // enable low: no capture, and raising enable in hold does not capture
        enable = 1'b0;
        key_n = 4'b1110;
        tick(10);
        chk("t6_dis_level", keys_level, 4'b0001);
        chk("t6_dis_valid", {3'b0, note_valid}, 4'b0000);
        enable = 1'b1;
        tick(3);
        chk("t6_en_hold", {3'b0, note_valid}, 4'b0000);
        chk("t6_en_ovr", {3'b0, overrun}, 4'b0000);
        key_n = 4'hF;
        tick(8);
        chk("t6_final_valid", {3'b0, note_valid}, 4'b0000);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end
endmodule
